frame_stream_gen: RTL and testbench

- Parametrised raster test-frame source: generates vsync/hsync/valid timing for a configurable frame geometry and streams multi-channel pixel data in the active region.
- Pixels come from an upstream valid/ready source through an internal FIFO.
- Supports single-shot or continuous frames, prefill gating, underrun flagging and a frame counter.
- Feeds the network input path in place of the fixed 28x28, 1-bit test buffer.

---
 rtl/frame_stream_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_frame_stream_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_gen.sv
// Raster test-frame source: sync/valid timing for a configurable geometry,
// with pixel data streamed from an upstream valid/ready port through a FIFO.
module frame_stream_gen #(
    parameter int WDATA      = 8,
    parameter int CHANNELS   = 1,
    parameter int H_FBLANK   = 5,
    parameter int H_ACTIVE   = 28,
    parameter int H_BBLANK   = 5,
    parameter int H_SYNC     = 5,
    parameter int V_FBLANK   = 1,
    parameter int V_ACTIVE   = 28,
    parameter int V_BBLANK   = 1,
    parameter int V_SYNC     = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 4
) (
    input  logic                      i_sclk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_cont,
    input  logic [WDATA*CHANNELS-1:0] i_tdata,
    input  logic                      i_tvalid,
    output logic                      o_tready,
    output logic                      o_vsync,
    output logic                      o_hsync,
    output logic                      o_valid,
    output logic [WDATA*CHANNELS-1:0] o_tdata,
    output logic                      o_vdone,
    output logic                      o_busy,
    output logic                      o_underrun,
    output logic [15:0]               o_frame_cnt
);

    localparam int DW      = WDATA * CHANNELS;
    localparam int H_TOTAL = H_FBLANK + H_ACTIVE + H_BBLANK;
    localparam int V_TOTAL = V_FBLANK + V_ACTIVE + V_BBLANK;
    localparam int CW      = $clog2(H_TOTAL);
    localparam int RW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] COL_ZERO     = CW'(0);
    localparam logic [CW-1:0] COL_ONE      = CW'(1);
    localparam logic [CW-1:0] COL_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] COL_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] COL_ACT_BEG  = CW'(H_FBLANK);
    localparam logic [CW-1:0] COL_ACT_END  = CW'(H_FBLANK + H_ACTIVE);
    localparam logic [RW-1:0] ROW_ZERO     = RW'(0);
    localparam logic [RW-1:0] ROW_ONE      = RW'(1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(V_TOTAL - 1);
    localparam logic [RW-1:0] ROW_SYNC_END = RW'(V_SYNC);
    localparam logic [RW-1:0] ROW_ACT_BEG  = RW'(V_FBLANK);
    localparam logic [RW-1:0] ROW_ACT_END  = RW'(V_FBLANK + V_ACTIVE);
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);
    localparam logic [LW-1:0] LVL_ZERO     = LW'(0);
    localparam logic [LW-1:0] LVL_ONE      = LW'(1);
    localparam logic [LW-1:0] LVL_FULL     = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_PRE      = LW'(PREFILL);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];

    logic          valid_q, valid_d;
    logic          vsync_q, vsync_d;
    logic          hsync_q, hsync_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          vdone_q, vdone_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic in_run_s, row_act_s, hs_s, vs_s, act_s, last_pos_s;
    logic fifo_empty_s, wr_en_s, rd_en_s;

    assign o_tready = (level_q < LVL_FULL);

    // Timing decode from the raster counters; silent outside RUN.
    always_comb begin
        in_run_s   = (state_q == ST_RUN);
        row_act_s  = (row_q >= ROW_ACT_BEG) && (row_q < ROW_ACT_END);
        hs_s       = in_run_s && row_act_s && (col_q < COL_SYNC_END);
        vs_s       = in_run_s && (row_q < ROW_SYNC_END);
        act_s      = in_run_s && row_act_s && (col_q >= COL_ACT_BEG) && (col_q < COL_ACT_END);
        last_pos_s = in_run_s && (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    // FIFO pointer and level bookkeeping; an empty read is simply skipped.
    always_comb begin
        fifo_empty_s = (level_q == LVL_ZERO);
        wr_en_s      = i_tvalid && o_tready;
        rd_en_s      = act_s && !fifo_empty_s;
        wr_ptr_d     = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer and raster counters.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                col_d = COL_ZERO;
                row_d = ROW_ZERO;
                if (i_start) begin
                    state_d = ST_PREFILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREFILL: begin
                col_d = COL_ZERO;
                row_d = ROW_ZERO;
                if (level_q >= LVL_PRE) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PREFILL;
                end
            end
            ST_RUN: begin
                if (col_q == COL_LAST) begin
                    col_d = COL_ZERO;
                    if (row_q == ROW_LAST) begin
                        row_d       = ROW_ZERO;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // Continuous mode chains straight into the next frame when data is ready.
                        if (!i_cont) begin
                            state_d = ST_IDLE;
                        end else if (level_q >= LVL_PRE) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_PREFILL;
                        end
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        valid_d = act_s;
        vsync_d = vs_s;
        hsync_d = hs_s;
        vdone_d = last_pos_s;
        busy_d  = (state_d != ST_IDLE);
        if (act_s) begin
            tdata_d = fifo_empty_s ? {DW{1'b0}} : mem_q[rd_ptr_q];
        end else begin
            tdata_d = tdata_q;
        end
        if ((state_q == ST_IDLE) && i_start) begin
            underrun_d = 1'b0;
        end else if (act_s && fifo_empty_s) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_sclk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= i_tdata;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            col_q       <= COL_ZERO;
            row_q       <= ROW_ZERO;
            level_q     <= LVL_ZERO;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            valid_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            tdata_q     <= {DW{1'b0}};
            vdone_q     <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            tdata_q     <= tdata_d;
            vdone_q     <= vdone_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_vsync     = vsync_q;
    assign o_hsync     = hsync_q;
    assign o_tdata     = tdata_q;
    assign o_vdone     = vdone_q;
    assign o_busy      = busy_q;
    assign o_underrun  = underrun_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed bench for frame_stream_gen: upstream writes feed a scoreboard queue,
// popped and compared whenever the generator emits a valid pixel.
module tb_frame_stream_gen;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_cont;
    logic [7:0]  i_tdata;
    logic        i_tvalid;
    logic        o_tready;
    logic        o_vsync;
    logic        o_hsync;
    logic        o_valid;
    logic [7:0]  o_tdata;
    logic        o_vdone;
    logic        o_busy;
    logic        o_underrun;
    logic [15:0] o_frame_cnt;

    frame_stream_gen dut (
        .i_sclk      (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_cont      (i_cont),
        .i_tdata     (i_tdata),
        .i_tvalid    (i_tvalid),
        .o_tready    (o_tready),
        .o_vsync     (o_vsync),
        .o_hsync     (o_hsync),
        .o_valid     (o_valid),
        .o_tdata     (o_tdata),
        .o_vdone     (o_vdone),
        .o_busy      (o_busy),
        .o_underrun  (o_underrun),
        .o_frame_cnt (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb_q[$];
    int         cyc = 0;
    int         src_budget = 0;
    logic       underrun_exp = 1'b0;
    int         n_pix, vs_cnt, hs_cnt, vdone_total, first_val_edge, first_vs_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: sample the write handshake, step the edge, check outputs, then record the write.
    task automatic tick();
        logic       wr;
        logic [7:0] wd;
        logic [7:0] expv;
        wr = i_tvalid && o_tready;
        wd = i_tdata;
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid) begin
            n_pix++;
            if (first_val_edge < 0) first_val_edge = cyc;
            if (sb_q.size() > 0) begin
                expv = sb_q.pop_front();
            end else begin
                expv = 8'd0;
                underrun_exp = 1'b1;
            end
            chk("pixel_data", 32'(o_tdata), 32'(expv));
            chk("underrun_flag", 32'(o_underrun), 32'(underrun_exp));
        end
        if (o_vsync) begin
            vs_cnt++;
            if (first_vs_edge < 0) first_vs_edge = cyc;
        end
        if (o_hsync) hs_cnt++;
        if (o_vdone) vdone_total++;
        if (wr) begin
            sb_q.push_back(wd);
            i_tdata = i_tdata + 8'd1;
            if (src_budget > 0) begin
                src_budget--;
                if (src_budget == 0) i_tvalid = 1'b0;
            end
        end
    endtask

    task automatic clr_stats();
        n_pix = 0; vs_cnt = 0; hs_cnt = 0; vdone_total = 0;
        first_val_edge = -1; first_vs_edge = -1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        underrun_exp = 1'b0;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_vdone(input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_vdone) begin
                e = cyc;
                break;
            end
        end
        vectors++;
        assert (e >= 0) else begin
            miscompares++;
            $error("FAIL vdone_timeout observed=none expected=pulse within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        sb_q.delete();
        underrun_exp = 1'b0;
    endtask

    initial begin
        int s, e, w, prev;
        i_rst = 1'b0; i_start = 1'b0; i_cont = 1'b0; i_tdata = 8'd0; i_tvalid = 1'b0;
        clr_stats();
        #2 i_rst = 1'b1;
        #2;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_vsync", 32'(o_vsync), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("rst_tready", 32'(o_tready), 32'd1);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Single frame, source always valid; FIFO fills to full while idle.
        i_tvalid = 1'b1; src_budget = 0;
        repeat (20) tick();
        chk("idle_full_tready", 32'(o_tready), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        clr_stats();
        pulse_start();
        s = cyc;
        chk("prefill_busy", 32'(o_busy), 32'd1);
        wait_vdone(1300, e);
        chk("f1_vdone_latency", 32'(e - s), 32'd1141);
        chk("f1_first_valid_latency", 32'(first_val_edge - s), 32'd45);
        chk("f1_vsync_first", 32'(first_vs_edge - s), 32'd2);
        chk("f1_vsync_cycles", 32'(vs_cnt), 32'd38);
        chk("f1_hsync_cycles", 32'(hs_cnt), 32'd140);
        chk("f1_pixels", 32'(n_pix), 32'd784);
        chk("f1_frame_cnt", 32'(o_frame_cnt), 32'd1);
        chk("f1_busy_after", 32'(o_busy), 32'd0);
        tick();
        chk("f1_vdone_one_cycle", 32'(o_vdone), 32'd0);
        chk("f1_tdata_hold", 32'(o_tdata), 32'd15);

        // Prefill gate with three pixels, then a 100-pixel source leading to underrun.
        do_reset();
        clr_stats();
        i_tdata = 8'd0; i_tvalid = 1'b1; src_budget = 3;
        repeat (3) tick();
        pulse_start();
        repeat (20) tick();
        chk("gate_busy", 32'(o_busy), 32'd1);
        chk("gate_no_vsync", 32'(vs_cnt), 32'd0);
        chk("gate_no_hsync", 32'(hs_cnt), 32'd0);
        chk("gate_no_valid", 32'(n_pix), 32'd0);
        src_budget = 97; i_tvalid = 1'b1;
        tick();
        w = cyc;
        wait_vdone(1300, e);
        chk("gate_first_valid_latency", 32'(first_val_edge - w), 32'd45);
        chk("gate_vdone_latency", 32'(e - w), 32'd1141);
        chk("ur_pixels", 32'(n_pix), 32'd784);
        chk("ur_flag_set", 32'(o_underrun), 32'd1);
        repeat (10) tick();
        chk("ur_flag_sticky", 32'(o_underrun), 32'd1);
        pulse_start();
        chk("ur_cleared_by_start", 32'(o_underrun), 32'd0);
        repeat (5) tick();
        chk("ur_prefill_waits", 32'(o_busy), 32'd1);

        // Continuous mode: three back-to-back frames, stray starts mid-frame.
        do_reset();
        i_tvalid = 1'b1; src_budget = 0; i_cont = 1'b1;
        repeat (20) tick();
        clr_stats();
        pulse_start();
        s = cyc;
        prev = s + 1;
        for (int k = 1; k <= 3; k++) begin
            e = -1;
            for (int i = 0; i < 1300; i++) begin
                tick();
                i_start = (i == 300) ? 1'b1 : 1'b0;
                if (o_vdone) begin
                    e = cyc;
                    break;
                end
            end
            i_start = 1'b0;
            chk("cont_frame_period", 32'(e - prev), 32'd1140);
            chk("cont_frame_cnt", 32'(o_frame_cnt), 32'(k));
            prev = e;
            if (k == 2) i_cont = 1'b0;
        end
        chk("cont_pixels", 32'(n_pix), 32'd2352);
        chk("cont_vsync_cycles", 32'(vs_cnt), 32'd114);
        chk("cont_vdone_count", 32'(vdone_total), 32'd3);
        chk("cont_busy_after", 32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of a running frame.
        do_reset();
        i_tvalid = 1'b1; src_budget = 0; i_cont = 1'b0;
        repeat (20) tick();
        pulse_start();
        repeat (300) tick();
        chk("mid_busy", 32'(o_busy), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_tdata", 32'(o_tdata), 32'd0);
        chk("arst_vsync", 32'(o_vsync), 32'd0);
        chk("arst_hsync", 32'(o_hsync), 32'd0);
        chk("arst_vdone", 32'(o_vdone), 32'd0);
        chk("arst_underrun", 32'(o_underrun), 32'd0);
        chk("arst_tready", 32'(o_tready), 32'd1);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        sb_q.delete();
        i_tvalid = 1'b0;
        clr_stats();
        repeat (1200) tick();
        chk("post_rst_no_vdone", 32'(vdone_total), 32'd0);
        chk("post_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("post_rst_tready", 32'(o_tready), 32'd1);
        chk("post_rst_busy", 32'(o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
